hangman_guess_checker: RTL

HANGMAN_GUESS_CHECKER -- requirements
Module: hangman_guess_checker

---
 rtl/hangman_pkg.sv | 27 ++
 rtl/hangman_slot_match.sv | 32 +++
 rtl/hangman_guess_checker.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/hangman_pkg.sv
// ============================================================================
// Module      : hangman_pkg
// Description : Shared letter codes, game limits and FSM encoding for the
//               hangman guess checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hangman_pkg;

    localparam int LETTER_W   = 5;
    localparam int BLANK      = 0;
    localparam int LETTER_Z   = 26;
    localparam int MAX_MISSES = 6;
    localparam int NUM_SLOTS  = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_CHECK = 3'd2,
        ST_WIN   = 3'd3,
        ST_LOSE  = 3'd4
    } state_t;

endpackage : hangman_pkg

`default_nettype wire

// File: rtl/hangman_slot_match.sv
// ============================================================================
// Module      : hangman_slot_match
// Description : Combinational per-slot compare of a guess against the word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hangman_slot_match #(
    parameter int LETTER_W = 5
) (
    input  logic [5:0][LETTER_W-1:0] i_slots,
    input  logic [LETTER_W-1:0]      i_guess,
    input  logic [5:0]               i_revealed,
    output logic [5:0]               o_match,
    output logic                     o_any_letter
);

    logic [5:0] w_eq;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_slot
            assign w_eq[gi] = (i_slots[gi] == i_guess);
        end
    endgenerate

    // A letter already on display is still "in the word": it must not count as a miss.
    assign o_match      = w_eq & ~i_revealed;
    assign o_any_letter = |w_eq;

endmodule : hangman_slot_match

`default_nettype wire

// File: rtl/hangman_guess_checker.sv
// ============================================================================
// Module      : hangman_guess_checker
// Description : Hangman game controller: latches a six-letter word, checks
//               guesses, reveals slots and tracks misses to WIN/LOSE.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hangman_guess_checker #(
    parameter int MAX_MISSES = 6,
    parameter int LETTER_W   = 5
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                i_word_load,
    input  logic [LETTER_W-1:0] i_slot_a,
    input  logic [LETTER_W-1:0] i_slot_b,
    input  logic [LETTER_W-1:0] i_slot_c,
    input  logic [LETTER_W-1:0] i_slot_d,
    input  logic [LETTER_W-1:0] i_slot_e,
    input  logic [LETTER_W-1:0] i_slot_f,
    input  logic                i_guess_valid,
    input  logic [LETTER_W-1:0] i_guess_letter,
    output logic                o_guess_ready,
    output logic                o_hit_a,
    output logic                o_hit_b,
    output logic                o_hit_c,
    output logic                o_hit_d,
    output logic                o_hit_e,
    output logic                o_hit_f,
    output logic [5:0]          o_revealed,
    output logic                o_miss_pulse,
    output logic [2:0]          o_miss_count,
    output logic                o_win,
    output logic                o_lose
);

    import hangman_pkg::*;

    localparam logic [2:0] C_MAX_MISS = 3'(MAX_MISSES);

    state_t                    r_state;
    logic [5:0][LETTER_W-1:0]  r_slots;
    logic [LETTER_W-1:0]       r_guess;
    logic [5:0]                r_revealed;
    logic [5:0]                r_hit;
    logic                      r_miss_pulse;
    logic [2:0]                r_miss_count;
    logic                      r_ready;
    logic                      r_win;
    logic                      r_lose;

    logic [5:0][LETTER_W-1:0]  w_slots_in;
    logic [5:0]                w_blank_in;
    logic [5:0]                w_match;
    logic                      w_any_letter;
    logic [5:0]                w_rev_next;
    logic [2:0]                w_miss_next;
    logic                      w_legal;

    assign w_slots_in = {i_slot_a, i_slot_b, i_slot_c, i_slot_d, i_slot_e, i_slot_f};

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_blank
            assign w_blank_in[gi] = (w_slots_in[gi] == LETTER_W'(BLANK));
        end
    endgenerate

    assign w_legal = (i_guess_letter != LETTER_W'(BLANK)) &&
                     (i_guess_letter <= LETTER_W'(LETTER_Z));

    hangman_slot_match #(
        .LETTER_W (LETTER_W)
    ) u_slot_match (
        .i_slots      (r_slots),
        .i_guess      (r_guess),
        .i_revealed   (r_revealed),
        .o_match      (w_match),
        .o_any_letter (w_any_letter)
    );

    assign w_rev_next  = r_revealed | w_match;
    assign w_miss_next = (!w_any_letter && (r_miss_count < C_MAX_MISS)) ?
                         r_miss_count + 3'd1 : r_miss_count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_slots      <= '0;
            r_guess      <= '0;
            r_revealed   <= '0;
            r_hit        <= '0;
            r_miss_pulse <= 1'b0;
            r_miss_count <= '0;
            r_ready      <= 1'b0;
            r_win        <= 1'b0;
            r_lose       <= 1'b0;
        end else begin
            r_hit        <= '0;
            r_miss_pulse <= 1'b0;
            if (i_word_load) begin
                r_slots      <= w_slots_in;
                r_revealed   <= w_blank_in;
                r_miss_count <= '0;
                r_win        <= 1'b0;
                r_lose       <= 1'b0;
                r_state      <= ST_PLAY;
                // A fully blank word is won immediately, so never offer a guess.
                r_ready      <= ~(&w_blank_in);
            end else begin
                case (r_state)
                    ST_PLAY: begin
                        if (&r_revealed) begin
                            r_state <= ST_WIN;
                            r_ready <= 1'b0;
                        end else if (i_guess_valid && r_ready && w_legal) begin
                            r_guess <= i_guess_letter;
                            r_state <= ST_CHECK;
                            r_ready <= 1'b0;
                        end
                    end
                    ST_CHECK: begin
                        r_hit        <= w_match;
                        r_revealed   <= w_rev_next;
                        r_miss_pulse <= ~w_any_letter;
                        r_miss_count <= w_miss_next;
                        if (&w_rev_next) begin
                            r_state <= ST_WIN;
                            r_ready <= 1'b0;
                        end else if (w_miss_next == C_MAX_MISS) begin
                            r_state <= ST_LOSE;
                            r_ready <= 1'b0;
                        end else begin
                            r_state <= ST_PLAY;
                            r_ready <= 1'b1;
                        end
                    end
                    ST_WIN: begin
                        r_win   <= 1'b1;
                        r_ready <= 1'b0;
                    end
                    ST_LOSE: begin
                        r_lose  <= 1'b1;
                        r_ready <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_guess_ready = r_ready;
    assign o_hit_a       = r_hit[5];
    assign o_hit_b       = r_hit[4];
    assign o_hit_c       = r_hit[3];
    assign o_hit_d       = r_hit[2];
    assign o_hit_e       = r_hit[1];
    assign o_hit_f       = r_hit[0];
    assign o_revealed    = r_revealed;
    assign o_miss_pulse  = r_miss_pulse;
    assign o_miss_count  = r_miss_count;
    assign o_win         = r_win;
    assign o_lose        = r_lose;

endmodule : hangman_guess_checker

`default_nettype wire
